// File: rtl/multiword_add_pkg.sv
// Shared definitions for the multi-word add/subtract controller.
// Holds the FSM state encoding and the default datapath geometry.
package multiword_add_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH     = 8;
    localparam int DEFAULT_NUM_WORDS = 4;

endpackage

// File: rtl/ripple_carry_adder.sv
// WIDTH-bit ripple-carry adder built from a chain of full-adder cells.
// Purely combinational; the carry ripples from bit 0 to bit WIDTH-1.
module ripple_carry_adder #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    logic [WIDTH:0] carry;

    assign carry[0] = cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        assign sum[i]     = a[i] ^ b[i] ^ carry[i];
        assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end

    assign cout = carry[WIDTH];

endmodule

// File: rtl/multiword_add_ctrl.sv
// Multi-word add/subtract controller: walks NUM_WORDS words through one shared
// WIDTH-bit ripple-carry adder, least-significant word first, one word per cycle.
module multiword_add_ctrl
    import multiword_add_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int NUM_WORDS = DEFAULT_NUM_WORDS
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic                       sub,
    input  logic [WIDTH*NUM_WORDS-1:0] op_a,
    input  logic [WIDTH*NUM_WORDS-1:0] op_b,
    output logic                       busy,
    output logic                       done,
    output logic [WIDTH*NUM_WORDS-1:0] result,
    output logic                       cout,
    output logic                       overflow
);

    localparam int IDX_W = $clog2(NUM_WORDS);
    localparam int TOT_W = WIDTH * NUM_WORDS;

    state_t             state;
    state_t             state_next;
    logic [IDX_W-1:0]   idx;
    logic               carry;
    logic [TOT_W-1:0]   a_reg;
    logic [TOT_W-1:0]   b_reg;
    logic               sub_reg;

    logic [WIDTH-1:0]   a_word;
    logic [WIDTH-1:0]   b_eff;
    logic               add_cin;
    logic [WIDTH-1:0]   add_sum;
    logic               add_cout;
    logic               last_word;
    logic               capture;

    assign last_word = (idx == IDX_W'(NUM_WORDS - 1));
    assign capture   = (state == IDLE) && start;

    // Subtraction is a + ~b + 1: invert b here and inject the +1 as word 0's carry-in.
    always_comb begin
        a_word  = a_reg[int'(idx) * WIDTH +: WIDTH];
        b_eff   = b_reg[int'(idx) * WIDTH +: WIDTH] ^ {WIDTH{sub_reg}};
        add_cin = (idx == '0) ? sub_reg : carry;
    end

    ripple_carry_adder #(
        .WIDTH (WIDTH)
    ) u_adder (
        .a    (a_word),
        .b    (b_eff),
        .cin  (add_cin),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // NOTE: every output of this block gets a default before the case so no
    // path leaves a variable unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        unique case (state)
            IDLE: if (start) state_next = RUN;
            RUN: begin
                busy = 1'b1;
                if (last_word) state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order within the block.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            idx      <= '0;
            carry    <= 1'b0;
            result   <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            state <= state_next;
            if (capture) begin
                idx <= '0;
            end else if (state == RUN) begin
                result[int'(idx) * WIDTH +: WIDTH] <= add_sum;
                carry <= add_cout;
                idx   <= idx + 1'b1;
                if (last_word) begin
                    cout     <= add_cout;
                    overflow <= (a_word[WIDTH-1] == b_eff[WIDTH-1]) &&
                                (add_sum[WIDTH-1] != a_word[WIDTH-1]);
                end
            end
        end
    end

    // NOTE: operand holding registers carry no reset; they are only read in RUN,
    // which is always entered through a capture that loads them.
    always_ff @(posedge clk) begin
        if (rst_n && capture) begin
            a_reg   <= op_a;
            b_reg   <= op_b;
            sub_reg <= sub;
        end
    end

endmodule

// File: tb/tb_multiword_add_ctrl.sv
// Directed self-checking bench for multiword_add_ctrl at WIDTH=8, NUM_WORDS=4.
// Outputs are sampled on the falling edge; inputs are driven on the falling edge.
module tb_multiword_add_ctrl;

    localparam int WIDTH     = 8;
    localparam int NUM_WORDS = 4;
    localparam int TOT_W     = WIDTH * NUM_WORDS;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic             sub;
    logic [TOT_W-1:0] op_a;
    logic [TOT_W-1:0] op_b;
    logic             busy;
    logic             done;
    logic [TOT_W-1:0] result;
    logic             cout;
    logic             overflow;

    int checks = 0;
    int errors = 0;

    multiword_add_ctrl #(
        .WIDTH     (WIDTH),
        .NUM_WORDS (NUM_WORDS)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .sub      (sub),
        .op_a     (op_a),
        .op_b     (op_b),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .cout     (cout),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Launch one operation, scramble the operand inputs after capture, and wait
    // (bounded) for done. Returns with the bench sitting on the done cycle.
    task automatic run_op(input logic s, input logic [TOT_W-1:0] a, input logic [TOT_W-1:0] b,
                          output int lat, output int busy_cycles);
        @(negedge clk);
        start = 1'b1;
        sub   = s;
        op_a  = a;
        op_b  = b;
        @(posedge clk);
        lat         = 0;
        busy_cycles = 0;
        @(negedge clk);
        start = 1'b0;
        sub   = ~s;
        op_a  = $urandom;
        op_b  = $urandom;
        while (!done && lat < 20) begin
            if (busy) busy_cycles++;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic op_and_check(input string tag, input logic s,
                                input logic [TOT_W-1:0] a, input logic [TOT_W-1:0] b,
                                input logic [TOT_W-1:0] exp_res, input logic exp_c,
                                input logic exp_ov);
        int lat;
        int bc;
        run_op(s, a, b, lat, bc);
        check({tag, "_latency"}, 64'(lat), 64'd4);
        check({tag, "_result"}, 64'(result), 64'(exp_res));
        check({tag, "_cout"}, 64'(cout), 64'(exp_c));
        check({tag, "_overflow"}, 64'(overflow), 64'(exp_ov));
        @(negedge clk);
        check({tag, "_done_single"}, 64'(done), 64'd0);
    endtask

    initial begin
        int lat;
        int bc;
        int pulses;
        logic [TOT_W-1:0] seen_res;
        logic saw_busy;

        rst_n = 1'b0;
        start = 1'b0;
        sub   = 1'b0;
        op_a  = '0;
        op_b  = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_result", 64'(result), 64'd0);
        check("rst_cout", 64'(cout), 64'd0);
        check("rst_overflow", 64'(overflow), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // First operation also checks busy duration and result hold after DONE.
        run_op(1'b0, 32'h0000_00FF, 32'h0000_0001, lat, bc);
        check("add_ff_latency", 64'(lat), 64'd4);
        check("add_ff_busy_cycles", 64'(bc), 64'd4);
        check("add_ff_result", 64'(result), 64'h0000_0100);
        check("add_ff_cout", 64'(cout), 64'd0);
        check("add_ff_overflow", 64'(overflow), 64'd0);
        repeat (3) @(negedge clk);
        check("hold_result", 64'(result), 64'h0000_0100);
        check("hold_done_low", 64'(done), 64'd0);
        check("hold_busy_low", 64'(busy), 64'd0);

        op_and_check("add_wrap", 1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0);
        op_and_check("add_ovf", 1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b1);
        op_and_check("add_mix", 1'b0, 32'h1234_5678, 32'h9ABC_DEF0, 32'hACF1_3568, 1'b0, 1'b0);
        op_and_check("sub_borrow", 1'b1, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b0);
        op_and_check("sub_small", 1'b1, 32'h0000_0005, 32'h0000_0003, 32'h0000_0002, 1'b1, 1'b0);
        op_and_check("sub_ovf", 1'b1, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1, 1'b1);

        // start held high with changing operands throughout RUN must be ignored.
        @(negedge clk);
        start = 1'b1;
        sub   = 1'b0;
        op_a  = 32'h1111_1111;
        op_b  = 32'h2222_2222;
        @(posedge clk);
        pulses   = 0;
        lat      = 0;
        seen_res = '0;
        @(negedge clk);
        while (lat < 20) begin
            if (done) begin
                pulses++;
                seen_res = result;
                start    = 1'b0;
                break;
            end
            start = 1'b1;
            sub   = 1'($urandom);
            op_a  = $urandom;
            op_b  = $urandom;
            @(negedge clk);
            lat++;
        end
        repeat (8) begin
            @(negedge clk);
            if (done) pulses++;
        end
        check("restart_latency", 64'(lat), 64'd4);
        check("restart_result", 64'(seen_res), 64'h3333_3333);
        check("restart_pulses", 64'(pulses), 64'd1);

        // Reset asserted during the second RUN cycle aborts the operation.
        @(negedge clk);
        start = 1'b1;
        sub   = 1'b0;
        op_a  = 32'h0F0F_0F0F;
        op_b  = 32'h0101_0101;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        check("abort_busy_run1", 64'(busy), 64'd1);
        @(negedge clk);
        check("abort_busy_run2", 64'(busy), 64'd1);
        rst_n = 1'b0;
        start = 1'b1;
        @(negedge clk);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_result", 64'(result), 64'd0);
        check("abort_cout", 64'(cout), 64'd0);
        check("abort_overflow", 64'(overflow), 64'd0);
        rst_n = 1'b1;
        start = 1'b0;
        pulses   = 0;
        saw_busy = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (done) pulses++;
            if (busy) saw_busy = 1'b1;
        end
        check("abort_no_done", 64'(pulses), 64'd0);
        check("abort_no_busy", 64'(saw_busy), 64'd0);

        op_and_check("post_abort", 1'b0, 32'h1234_5678, 32'h9ABC_DEF0, 32'hACF1_3568, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/multiword_add_ctrl.md
MULTIWORD_ADD_CTRL -- requirements
Module: multiword_add_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8: word width of the shared adder datapath, in bits.
REQ-002 The block SHALL have parameter NUM_WORDS, default 4: number of words per operand (NUM_WORDS >= 2).
REQ-003 Port clk  input  1  the only clock; all state updates on its rising edge.
REQ-004 Port rst_n  input  1  reset, synchronous and active-low.
REQ-005 Port start  input  1  request a new operation; sampled only in IDLE.
REQ-006 Port sub  input  1  operation select: 0 = op_a+op_b, 1 = op_a-op_b; captured with start.
REQ-007 Port op_a  input  WIDTH*NUM_WORDS  first operand; captured with start.
REQ-008 Port op_b  input  WIDTH*NUM_WORDS  second operand; captured with start.
REQ-009 Port busy  output  1  high while an operation is in progress (RUN state).
REQ-010 Port done  output  1  single-cycle pulse: result, cout and overflow are valid.
REQ-011 Port result  output  WIDTH*NUM_WORDS  sum or difference, modulo 2^(WIDTH*NUM_WORDS).
REQ-012 Port cout  output  1  final carry out; for sub, 1 = no borrow.
REQ-013 Port overflow  output  1  two's-complement signed overflow of the full-width operation.

Function
REQ-014 The FSM SHALL have states IDLE, RUN and DONE.
REQ-015 IDLE -> RUN on a rising edge with start=1; op_a, op_b and sub SHALL be captured on that edge.
REQ-016 In RUN, the block SHALL feed one WIDTH-bit word per cycle to a single ripple_carry_adder instance, least-significant word first, with a word index counter 0..NUM_WORDS-1.
REQ-017 For word 0, adder cin SHALL equal sub; for word i>0, adder cin SHALL be the registered cout of word i-1.
REQ-018 When sub=1, the adder b input SHALL be the bitwise inverse of the op_b word; otherwise it SHALL be the op_b word unchanged.
REQ-019 Each cycle in RUN, the adder sum SHALL be written into result word [index], and adder cout SHALL be registered as the inter-word carry.
REQ-020 RUN -> DONE on the edge that writes word NUM_WORDS-1; on that edge cout SHALL take the adder cout and overflow SHALL be set to (a_msb == b_eff_msb) && (sum_msb != a_msb) for the top word.
REQ-021 DONE -> IDLE unconditionally after one cycle; done SHALL be 1 only in DONE.
REQ-022 Latency: start sampled at edge k -> done high in the cycle after edge k+NUM_WORDS (NUM_WORDS+1 cycles after the start edge).
REQ-023 busy SHALL be 1 exactly in RUN (NUM_WORDS cycles per operation).
REQ-024 start in RUN or DONE SHALL be ignored, with no capture and no queueing; the in-flight operation SHALL be unaffected.
REQ-025 result, cout and overflow SHALL hold their last values from DONE until the next operation's first write.
REQ-026 Operand-input changes after capture SHALL NOT affect the operation in progress.

Reset
REQ-027 On a rising edge with rst_n=0, the state SHALL become IDLE and the index, inter-word carry, result, cout, overflow, busy and done SHALL all become 0.
REQ-028 Reset in RUN or DONE SHALL abort the operation with no done pulse; start SHALL be ignored while rst_n=0.

Structure
REQ-029 Shared package multiword_add_pkg SHALL hold the state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the default WIDTH and NUM_WORDS constants.
REQ-030 The datapath SHALL be exactly one existing ripple_carry_adder #(.WIDTH(WIDTH)) sub-module; no other adder logic is permitted.
REQ-031 The index counter SHALL be $clog2(NUM_WORDS) bits wide.

Verification (WIDTH=8, NUM_WORDS=4)
REQ-032 add 0x000000FF + 0x00000001 -> result 0x00000100, cout 0, overflow 0; done exactly 5 cycles after the start edge; busy high 4 cycles.
REQ-033 add 0xFFFFFFFF + 0x00000001 -> result 0x00000000, cout 1, overflow 0; add 0x7FFFFFFF + 0x00000001 -> 0x80000000, cout 0, overflow 1.
REQ-034 sub 0x00000000 - 0x00000001 -> 0xFFFFFFFF, cout 0 (borrow); sub 0x80000000 - 0x00000001 -> 0x7FFFFFFF, overflow 1.
REQ-035 start re-asserted every cycle during RUN with different operands -> the first operation's result is unchanged and exactly one done pulse occurs.
REQ-036 rst_n low on the 2nd RUN cycle -> next cycle IDLE with all outputs 0 and no done; a new start afterwards completes correctly.
